// File: rtl/led_mem_reader.sv
// Read-side sequencer for the LED pattern memory: shows mem[0..LAST_ADDR], one pattern
// per TICK_CYCLES clocks, then holds the last pattern until run drops.
module led_mem_reader #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4,
  parameter int LAST_ADDR   = 15,
  parameter int TICK_CYCLES = 100000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] led,
  output logic [ADDR_W-1:0] step,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_W'(TICK_CYCLES - 2);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]   LAST_X   = (ADDR_W + 1)'(LAST_ADDR);
  localparam logic [ADDR_W:0]   ONE_X    = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME_RD,
    S_PRIME_CAP,
    S_RUN,
    S_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   led_q, led_d;
  logic [ADDR_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W:0]     step_inc;
  logic [ADDR_W:0]     step_d_inc;

  always_comb begin
    state_d  = state_q;
    led_d    = led_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    step_inc = {1'b0, step_q} + ONE_X;

    case (state_q)
      S_IDLE: begin
        led_d  = '0;
        step_d = '0;
        cnt_d  = '0;
        if (run) state_d = S_PRIME_RD;
      end
      S_PRIME_RD: state_d = S_PRIME_CAP;
      S_PRIME_CAP: begin
        led_d   = mem_dout;
        step_d  = '0;
        cnt_d   = '0;
        state_d = (LAST_ADDR == 0) ? S_HOLD : S_RUN;
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) begin
          led_d  = mem_dout;
          step_d = step_inc[ADDR_W-1:0];
          cnt_d  = '0;
          if (step_inc == LAST_X) state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HOLD: ;
      default: state_d = S_IDLE;
    endcase

    // Stop overrides any update on the same edge; an in-flight read is simply never captured.
    if (state_q != S_IDLE && !run) begin
      state_d = S_IDLE;
      led_d   = '0;
      step_d  = '0;
      cnt_d   = '0;
    end

    // Strobes are registered, so they are decoded from the next-state values.
    step_d_inc = {1'b0, step_d} + ONE_X;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    if (state_d == S_PRIME_RD) begin
      mem_en_d   = 1'b1;
      mem_addr_d = '0;
    end else if (state_d == S_RUN && cnt_d == CNT_PRE) begin
      mem_en_d   = 1'b1;
      mem_addr_d = step_d_inc[ADDR_W-1:0];
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      led_q      <= '0;
      step_q     <= '0;
      cnt_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_en   = mem_en_q;
  assign mem_we   = 1'b0;
  assign mem_addr = mem_addr_q;
  assign led      = led_q;
  assign step     = step_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_led_mem_reader.sv
// Directed bench for led_mem_reader with a behavioural 1-cycle synchronous-read memory.
module tb_led_mem_reader;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic [DATA_W-1:0] mem_dout = '0;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] led;
  logic [ADDR_W-1:0] step;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mem [16];
  int checks = 0;
  int errors = 0;

  led_mem_reader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LAST_ADDR(15), .TICK_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .mem_dout(mem_dout),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .led(led), .step(step), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_dout <= mem[mem_addr];

  function automatic logic [31:0] pat(input int k);
    logic [31:0] v;
    v = (32'h1 << (k + 1)) - 32'h1;
    return {16'h0, v[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // From the negedge where run is already high in IDLE: expect led=mem[0] two edges later.
  task automatic start_seq();
    @(negedge clk);
    chk("prime_en", 32'(mem_en), 32'h1);
    chk("prime_addr", 32'(mem_addr), 32'h0);
    chk("prime_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("prime_led_off", 32'(led), 32'h0);
    @(negedge clk);
    chk("first_led", 32'(led), 32'h0001);
    chk("first_step", 32'(step), 32'h0);
  endtask

  task automatic run_steps(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      repeat (2) @(negedge clk);
      chk("rd_en", 32'(mem_en), 32'h1);
      chk("rd_addr", 32'(mem_addr), 32'(k));
      @(negedge clk);
      chk("rd_en_off", 32'(mem_en), 32'h0);
      chk("led_held", 32'(led), pat(k - 1));
      @(negedge clk);
      chk("led_next", 32'(led), pat(k));
      chk("step_next", 32'(step), 32'(k));
      chk("done_flag", 32'(done), (k == 15) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'((32'h1 << (i + 1)) - 32'h1);
    rst = 1'b1;
    run = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_en", 32'(mem_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_step", 32'(step), 32'h0);
    chk("we_tied", 32'(mem_we), 32'h0);
    rst = 1'b0;
    start_seq();

    // Full cadence up to the last pattern, then hold.
    run_steps(1, 15);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("hold_led", 32'(led), 32'hFFFF);
      chk("hold_en", 32'(mem_en), 32'h0);
      chk("hold_step", 32'(step), 32'd15);
      chk("hold_done", 32'(done), 32'h1);
    end

    // Stop from HOLD and replay up to 0x00FF.
    run = 1'b0;
    @(negedge clk);
    chk("stop_led", 32'(led), 32'h0);
    chk("stop_busy", 32'(busy), 32'h0);
    chk("stop_done", 32'(done), 32'h0);
    run = 1'b1;
    start_seq();
    run_steps(1, 7);

    // Stop while showing 0x00FF, then restart from address 0.
    run = 1'b0;
    @(negedge clk);
    chk("cut_led", 32'(led), 32'h0);
    chk("cut_busy", 32'(busy), 32'h0);
    chk("cut_step", 32'(step), 32'h0);
    run = 1'b1;
    start_seq();

    // Reset during RUN with a read in flight (cnt==2).
    repeat (2) @(negedge clk);
    chk("inflight_en", 32'(mem_en), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_led", 32'(led), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_en", 32'(mem_en), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_prime_en", 32'(mem_en), 32'h1);
    chk("mrst_stale_led", 32'(led), 32'h0);
    @(negedge clk);
    chk("mrst_stale_led2", 32'(led), 32'h0);
    @(negedge clk);
    chk("mrst_restart_led", 32'(led), 32'h0001);

    // Stop on the same edge as the 0x0007 -> 0x000F update.
    run_steps(1, 2);
    repeat (3) @(negedge clk);
    chk("same_edge_pre", 32'(led), 32'h0007);
    run = 1'b0;
    @(negedge clk);
    chk("same_edge_led", 32'(led), 32'h0);
    chk("same_edge_step", 32'(step), 32'h0);
    chk("same_edge_busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
